// File: rtl/send_data_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// default clock/baud values and the bit-divisor helper.
package send_data_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD0    = 9_600;
    localparam int unsigned DEF_BAUD1    = 19_200;
    localparam int unsigned DEF_BAUD2    = 38_400;
    localparam int unsigned DEF_BAUD3    = 115_200;

    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned CNT_W        = 16;

    // Frame phases of an 8N1 character.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } tx_state_e;

    // Clock cycles per bit for a given baud rate (integer divide).
    function automatic logic [CNT_W-1:0] calc_div(input int unsigned clk_freq,
                                                  input int unsigned baud);
        int unsigned div;
        div = clk_freq / baud;
        return div[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/send_data_if.sv
// Byte-source side of the UART transmitter: request strobe, data, baud
// select and the serial line with its status flags.
interface send_data_if;

    logic       tx_en;
    logic [7:0] tx_data;
    logic [1:0] choose;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_ready;
    logic       tx_stop;

    // Sequencer that supplies bytes.
    modport master (
        output tx_en,
        output tx_data,
        output choose,
        input  tx_out,
        input  tx_busy,
        input  tx_ready,
        input  tx_stop
    );

    // Transmitter.
    modport slave (
        input  tx_en,
        input  tx_data,
        input  choose,
        output tx_out,
        output tx_busy,
        output tx_ready,
        output tx_stop
    );

endinterface

// File: rtl/send_data_tx_bps.sv
// Bit-time generator: selects the divisor from the latched baud select and
// counts clock cycles within the current bit. The counter restarts on every
// FSM state entry and wraps by itself at each bit end.
module tx_bps
    import send_data_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD0    = DEF_BAUD0,
    parameter int unsigned BAUD1    = DEF_BAUD1,
    parameter int unsigned BAUD2    = DEF_BAUD2,
    parameter int unsigned BAUD3    = DEF_BAUD3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_choose,
    input  logic       i_restart,
    output logic       o_bit_end,
    output logic       o_bit_near_end
);

    localparam logic [CNT_W-1:0] DIV0 = calc_div(CLK_FREQ, BAUD0);
    localparam logic [CNT_W-1:0] DIV1 = calc_div(CLK_FREQ, BAUD1);
    localparam logic [CNT_W-1:0] DIV2 = calc_div(CLK_FREQ, BAUD2);
    localparam logic [CNT_W-1:0] DIV3 = calc_div(CLK_FREQ, BAUD3);

    logic [CNT_W-1:0] w_div;
    logic [CNT_W-1:0] r_cnt;

    // Divisor mux for the baud rate latched at frame start.
    always_comb begin
        // NOTE: a default before the case keeps this purely combinational; a path
        // that leaves w_div unassigned would infer a latch.
        w_div = DIV3;
        case (i_choose)
            2'b00:   w_div = DIV0;
            2'b01:   w_div = DIV1;
            2'b10:   w_div = DIV2;
            default: w_div = DIV3;
        endcase
    end

    // Cycle counter within the current bit.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples the
        // pre-edge values; blocking here would create order-dependent races.
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_restart || o_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Bit end on the last cycle; near-end lets the caller register a pulse
    // that lands exactly on the last cycle (needs a divisor of at least 2).
    assign o_bit_end      = (r_cnt == (w_div - 1'b1));
    assign o_bit_near_end = (r_cnt == (w_div - 2'd2));

endmodule

// File: rtl/send_data.sv
// UART transmitter: serialises one byte per accepted request as an 8N1 frame.
// A one-byte holding register lets the byte source queue the next byte while
// a frame is on the wire; a full hold at the end of a stop bit starts the next
// frame with no idle gap. All line-side outputs are registered.
module send_data
    import send_data_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD0    = DEF_BAUD0,
    parameter int unsigned BAUD1    = DEF_BAUD1,
    parameter int unsigned BAUD2    = DEF_BAUD2,
    parameter int unsigned BAUD3    = DEF_BAUD3
) (
    input  logic       clk,
    input  logic       rst,
    send_data_if.slave bus
);

    tx_state_e  r_state;
    tx_state_e  w_next_state;

    logic [7:0] r_hold_data;
    logic       r_hold_full;
    logic [7:0] r_shift;
    logic [7:0] w_next_shift;
    logic [2:0] r_bit_idx;
    logic [2:0] w_next_bit_idx;
    logic [1:0] r_choose;

    logic       r_tx_out;
    logic       r_tx_busy;
    logic       r_tx_stop;
    logic       w_next_tx_out;
    logic       w_next_tx_busy;
    logic       w_next_tx_stop;

    logic       w_accept;
    logic       w_load;
    logic       w_restart;
    logic       w_bit_end;
    logic       w_bit_near_end;

    // A request is taken only while the hold is empty.
    assign w_accept = bus.tx_en & ~r_hold_full;

    tx_bps #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD0    (BAUD0),
        .BAUD1    (BAUD1),
        .BAUD2    (BAUD2),
        .BAUD3    (BAUD3)
    ) u_bps (
        .clk            (clk),
        .rst            (rst),
        .i_choose       (r_choose),
        .i_restart      (w_restart),
        .o_bit_end      (w_bit_end),
        .o_bit_near_end (w_bit_near_end)
    );

    // Next-state, shift/bit-index update and next registered outputs.
    always_comb begin
        w_next_state   = r_state;
        w_next_shift   = r_shift;
        w_next_bit_idx = r_bit_idx;
        w_load         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_next_state = ST_START;
                    w_load       = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_next_state   = ST_DATA;
                    w_next_bit_idx = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_next_shift   = {1'b0, r_shift[7:1]};
                    w_next_bit_idx = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_next_state = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_hold_full) begin
                        w_next_state = ST_START;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase

        if (w_load) begin
            w_next_shift = r_hold_data;
        end

        // Line level follows the state being entered so it is valid from the
        // first cycle of each bit.
        case (w_next_state)
            ST_START: w_next_tx_out = 1'b0;
            ST_DATA:  w_next_tx_out = w_next_shift[0];
            default:  w_next_tx_out = 1'b1;
        endcase

        w_next_tx_busy = (w_next_state != ST_IDLE);
        // Registered one cycle early so the pulse sits on the last stop cycle.
        w_next_tx_stop = (r_state == ST_STOP) && w_bit_near_end;
        // Bit counter is held cleared in idle and restarted on every state entry.
        w_restart      = (w_next_state != r_state) || (r_state == ST_IDLE);
    end

    // FSM state, datapath and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_choose  <= '0;
            r_tx_out  <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_stop <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_next_shift;
            r_bit_idx <= w_next_bit_idx;
            r_tx_out  <= w_next_tx_out;
            r_tx_busy <= w_next_tx_busy;
            r_tx_stop <= w_next_tx_stop;
            if (w_load) begin
                r_choose <= bus.choose;
            end
        end
    end

    // Holding register: a write wins over a same-cycle unload, so the frame
    // start takes the old byte and the hold stays full with the new one.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the one-byte data store is reset as well so the line never shifts
        // out X values; only a large RAM would be left without reset.
        if (!rst) begin
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_data <= bus.tx_data;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    assign bus.tx_out   = r_tx_out;
    assign bus.tx_busy  = r_tx_busy;
    assign bus.tx_ready = ~r_hold_full;
    assign bus.tx_stop  = r_tx_stop;

endmodule

// File: tb/tb_send_data.sv
// Bench for send_data at CLK_FREQ=921600 (choose=11 -> 8 cycles/bit,
// choose=00 -> 96 cycles/bit). Stimulus pushes expected frames into a queue;
// a line monitor decodes each frame and compares it against the queue head.
module tb_send_data;

    localparam int unsigned CLK_FREQ = 921_600;
    localparam int          DIV_FAST = 8;
    localparam int          DIV_SLOW = 96;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         abort;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    send_data_if bus ();

    send_data #(
        .CLK_FREQ (CLK_FREQ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks    = 0;
    int   n_fail      = 0;
    int   cyc         = 0;
    int   stop_count  = 0;
    int   idle_glitch = 0;
    bit   in_frame    = 1'b0;
    exp_t exp_q[$];
    int   frame_starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (bus.tx_stop === 1'b1) stop_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int div, input bit abort);
        exp_t e;
        e.data  = d;
        e.div   = div;
        e.abort = abort;
        exp_q.push_back(e);
    endtask

    // Drive one request once tx_ready is high; acc_cyc is the accepting cycle.
    task automatic send(input logic [7:0] d, output int acc_cyc);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!bus.tx_ready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 2000) check("send_ready_wait", bus.tx_ready, 1);
        bus.tx_en   = 1'b1;
        bus.tx_data = d;
        acc_cyc     = cyc;
        @(negedge clk);
        bus.tx_en   = 1'b0;
    endtask

    // Wait until every expected frame has been seen and the line is idle.
    task automatic wait_idle(input string name);
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || in_frame || bus.tx_busy) && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, bus.tx_busy, 0);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: decodes frames and compares them with the queue head.
    initial begin : monitor
        exp_t e;
        logic lv;
        bit   ok_lvl, ok_busy, ok_stop, aborted;
        forever begin
            @(negedge clk);
            if (rst && bus.tx_out === 1'b0) begin
                in_frame = 1'b1;
                frame_starts.push_back(cyc);
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                end else begin
                    e.data = 8'h00; e.div = DIV_FAST; e.abort = 1'b0;
                end
                aborted = 1'b0;
                ok_busy = 1'b1;
                ok_stop = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    if (!aborted) begin
                        if (b == 0)      lv = 1'b0;
                        else if (b == 9) lv = 1'b1;
                        else             lv = e.data[b-1];
                        ok_lvl = 1'b1;
                        for (int k = 0; k < e.div; k++) begin
                            if (!aborted) begin
                                if (b != 0 || k != 0) @(negedge clk);
                                if (!rst) begin
                                    aborted = 1'b1;
                                end else begin
                                    if (bus.tx_out !== lv) ok_lvl = 1'b0;
                                    if (bus.tx_busy !== 1'b1) ok_busy = 1'b0;
                                    if (bus.tx_stop !== ((b == 9) && (k == e.div - 1))) ok_stop = 1'b0;
                                end
                            end
                        end
                        if (!aborted) check($sformatf("frame_%02h_bit%0d", e.data, b), ok_lvl, 1);
                    end
                end
                if (aborted) begin
                    check($sformatf("frame_%02h_abort_expected", e.data), e.abort, 1);
                end else begin
                    check($sformatf("frame_%02h_busy", e.data), ok_busy, 1);
                    check($sformatf("frame_%02h_stop_pulse", e.data), ok_stop, 1);
                    check($sformatf("frame_%02h_abort_missed", e.data), e.abort, 0);
                end
                in_frame = 1'b0;
            end else if (rst && (bus.tx_busy !== 1'b0 || bus.tx_stop !== 1'b0)) begin
                idle_glitch++;
            end
        end
    end

    initial begin : stimulus
        int acc, acc2, nf, s0;

        // Reset held with a pending request.
        bus.tx_en   = 1'b1;
        bus.tx_data = 8'hFF;
        bus.choose  = 2'b11;
        rst         = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx_out", bus.tx_out, 1);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_tx_busy", bus.tx_busy, 0);
        check("rst_tx_stop", bus.tx_stop, 0);
        rst       = 1'b1;
        bus.tx_en = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_nothing_sent", frame_starts.size(), 0);

        // Single byte A5 from idle.
        nf = frame_starts.size();
        s0 = stop_count;
        push_exp(8'hA5, DIV_FAST, 1'b0);
        send(8'hA5, acc);
        check("a5_ready_low", bus.tx_ready, 0);
        wait_idle("a5");
        check("a5_latency", frame_starts[nf] - acc, 2);
        check("a5_stop_count", stop_count - s0, 1);

        // Back-to-back 55 then 0F.
        nf = frame_starts.size();
        s0 = stop_count;
        push_exp(8'h55, DIV_FAST, 1'b0);
        push_exp(8'h0F, DIV_FAST, 1'b0);
        send(8'h55, acc);
        send(8'h0F, acc2);
        check("b2b_accept_while_busy", bus.tx_busy, 1);
        wait_idle("b2b");
        check("b2b_frames", frame_starts.size() - nf, 2);
        check("b2b_no_gap", frame_starts[nf+1] - frame_starts[nf], 80);
        check("b2b_stop_count", stop_count - s0, 2);

        // Overrun: 22 fills the hold, 33 and 44 must be dropped.
        nf = frame_starts.size();
        push_exp(8'h11, DIV_FAST, 1'b0);
        push_exp(8'h22, DIV_FAST, 1'b0);
        send(8'h11, acc);
        send(8'h22, acc);
        check("ovr_ready_low", bus.tx_ready, 0);
        bus.tx_en   = 1'b1;
        bus.tx_data = 8'h33;
        @(negedge clk);
        bus.tx_data = 8'h44;
        @(negedge clk);
        bus.tx_en   = 1'b0;
        wait_idle("ovr");
        check("ovr_frames", frame_starts.size() - nf, 2);

        // Baud switch mid-frame.
        nf = frame_starts.size();
        push_exp(8'h3C, DIV_FAST, 1'b0);
        push_exp(8'hC3, DIV_SLOW, 1'b0);
        send(8'h3C, acc);
        repeat (20) @(negedge clk);
        bus.choose = 2'b00;
        send(8'hC3, acc);
        wait_idle("baud");
        check("baud_frames", frame_starts.size() - nf, 2);
        check("baud_first_len", frame_starts[nf+1] - frame_starts[nf], 80);
        bus.choose = 2'b11;

        // Async reset in the middle of data bit 3 of 96 (bit 3 = 0).
        s0 = stop_count;
        push_exp(8'h96, DIV_FAST, 1'b1);
        send(8'h96, acc);
        repeat (36) @(negedge clk);
        check("arst_line_before", bus.tx_out, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_tx_out", bus.tx_out, 1);
        check("arst_tx_busy", bus.tx_busy, 0);
        check("arst_tx_stop", bus.tx_stop, 0);
        check("arst_tx_ready", bus.tx_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_stop", stop_count - s0, 0);
        check("arst_abort_consumed", exp_q.size(), 0);

        // Fresh byte after the reset.
        nf = frame_starts.size();
        s0 = stop_count;
        push_exp(8'h5A, DIV_FAST, 1'b0);
        send(8'h5A, acc);
        wait_idle("post");
        check("post_latency", frame_starts[nf] - acc, 2);
        check("post_stop_count", stop_count - s0, 1);

        check("idle_glitches", idle_glitch, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
